quadrature_step_generator: RTL and testbench

// Transmit side of the rotary-encoder interface: turns a step command (direction,

---
 rtl/quadrature_step_generator_pkg.sv | 42 ++++
 rtl/quadrature_step_generator_step_timer.sv | 35 +++
 rtl/quadrature_step_generator.sv | 130 +++++++++++++
 tb/tb_quadrature_step_generator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_step_generator_pkg.sv
// Shared encodings for the rotary step generator and the matching decoder:
// FSM states, Gray phase constants and direction constants.
package quadrature_step_generator_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StStep   = 2'd2,
    StFinish = 2'd3
  } state_e;

  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_10 = 2'b10;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Next {a,b} position; DIR_UP walks 00->10->11->01, DIR_DOWN the reverse.
  function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic dir);
    logic [1:0] nxt;
    nxt = ab;
    if (dir == DIR_UP) begin
      unique case (ab)
        GRAY_00: nxt = GRAY_10;
        GRAY_10: nxt = GRAY_11;
        GRAY_11: nxt = GRAY_01;
        default: nxt = GRAY_00;
      endcase
    end else begin
      unique case (ab)
        GRAY_00: nxt = GRAY_01;
        GRAY_01: nxt = GRAY_11;
        GRAY_11: nxt = GRAY_10;
        default: nxt = GRAY_00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/quadrature_step_generator_step_timer.sv
// Loadable down-counter pacing the gaps between phase transitions; tick marks
// the last enabled cycle before terminal count.
module quadrature_step_generator_step_timer #(
  parameter int unsigned DIV_LEN = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DIV_LEN-1:0] load_val_i,
  input  logic               en_i,
  output logic               tick_o
);

  logic [DIV_LEN-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - DIV_LEN'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i && (count_q == DIV_LEN'(1));

endmodule

// File: rtl/quadrature_step_generator.sv
// Turns a (direction, count, pacing) command into a registered two-phase Gray
// sequence on rotary_a/rotary_b. Phase persists across commands.
module quadrature_step_generator
  import quadrature_step_generator_pkg::*;
#(
  parameter int unsigned COUNT_LEN = 8,
  parameter int unsigned DIV_LEN   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_dir_i,
  input  logic [COUNT_LEN-1:0] cmd_steps_i,
  input  logic [DIV_LEN-1:0]   cmd_half_period_i,
  input  logic                 abort_i,
  output logic                 rotary_a_o,
  output logic                 rotary_b_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [COUNT_LEN-1:0] rem_q, rem_d;
  logic [DIV_LEN-1:0]   hp_q, hp_d;
  logic [1:0]           ab_q, ab_d;

  logic                 timer_load, timer_en, tick;
  logic [DIV_LEN-1:0]   timer_val, hp_in;
  logic                 accept;

  assign hp_in  = (cmd_half_period_i == '0) ? DIV_LEN'(1) : cmd_half_period_i;
  assign accept = cmd_valid_i && cmd_ready_o && !abort_i;

  // The phase register advances on the edge that enters StStep, so StWait only
  // covers hp-1 cycles and hp==1 skips StWait entirely.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    hp_d       = hp_q;
    ab_d       = ab_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    timer_val  = hp_q - DIV_LEN'(1);
    unique case (state_q)
      StIdle, StFinish: begin
        state_d = StIdle;
        if (accept) begin
          dir_d = cmd_dir_i;
          hp_d  = hp_in;
          if (cmd_steps_i == '0) begin
            rem_d   = '0;
            state_d = StFinish;
          end else if (hp_in == DIV_LEN'(1)) begin
            ab_d    = gray_next(ab_q, cmd_dir_i);
            rem_d   = cmd_steps_i - COUNT_LEN'(1);
            state_d = StStep;
          end else begin
            rem_d      = cmd_steps_i;
            timer_load = 1'b1;
            timer_val  = hp_in - DIV_LEN'(1);
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          timer_en = 1'b1;
          if (tick) begin
            ab_d    = gray_next(ab_q, dir_q);
            rem_d   = rem_q - COUNT_LEN'(1);
            state_d = StStep;
          end
        end
      end
      StStep: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (rem_q == '0) begin
          state_d = StFinish;
        end else if (hp_q == DIV_LEN'(1)) begin
          ab_d  = gray_next(ab_q, dir_q);
          rem_d = rem_q - COUNT_LEN'(1);
        end else begin
          timer_load = 1'b1;
          state_d    = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dir_q   <= DIR_UP;
      rem_q   <= '0;
      hp_q    <= DIV_LEN'(1);
      ab_q    <= GRAY_00;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      hp_q    <= hp_d;
      ab_q    <= ab_d;
    end
  end

  quadrature_step_generator_step_timer #(
    .DIV_LEN(DIV_LEN)
  ) u_step_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .tick_o     (tick)
  );

  assign rotary_a_o  = ab_q[1];
  assign rotary_b_o  = ab_q[0];
  assign busy_o      = (state_q == StWait) || (state_q == StStep);
  assign done_o      = (state_q == StFinish);
  assign cmd_ready_o = (state_q == StIdle) || (state_q == StFinish);

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Self-checking bench: command table plus hand-written abort/reset sequences;
// expected phase edges and done pulses are queued at issue time and matched
// against what the outputs actually do, cycle by cycle.
module tb_quadrature_step_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir, abort;
  logic [7:0]  cmd_steps;
  logic [15:0] cmd_half_period;
  logic        rotary_a, rotary_b, busy, done;

  always #5 clk = ~clk;

  quadrature_step_generator #(
    .COUNT_LEN(8),
    .DIV_LEN  (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_dir_i         (cmd_dir),
    .cmd_steps_i       (cmd_steps),
    .cmd_half_period_i (cmd_half_period),
    .abort_i           (abort),
    .rotary_a_o        (rotary_a),
    .rotary_b_o        (rotary_b),
    .busy_o            (busy),
    .done_o            (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // kind 0 = phase change (val = new {a,b}); kind 1 = done pulse (val = {a,b} then)
  typedef struct {
    int         kind;
    logic [1:0] val;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  logic [1:0] model_ab = 2'b00;

  function automatic logic [1:0] model_next(input logic [1:0] ab, input logic dir);
    logic [1:0] up_seq [4];
    int idx;
    up_seq[0] = 2'b00; up_seq[1] = 2'b10; up_seq[2] = 2'b11; up_seq[3] = 2'b01;
    idx = 0;
    for (int i = 0; i < 4; i++) if (up_seq[i] == ab) idx = i;
    return dir ? up_seq[(idx + 1) % 4] : up_seq[(idx + 3) % 4];
  endfunction

  task automatic handle_ev(input int kind, input logic [1:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: kind %0d value %0d at cycle %0d, none expected",
               kind, v, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_value", int'(v), int'(e.val));
      check("ev_cycle", cyc, e.at);
    end
  endtask

  logic       mon_en = 1'b0;
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] mon_ab;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ab = {rotary_a, rotary_b};
      if (mon_ab != prev_ab) handle_ev(0, mon_ab);
      if (done) handle_ev(1, mon_ab);
      prev_ab = mon_ab;
    end
  end

  // Called at a negedge. abort_at >= 0 raises abort during cycle c0+abort_at.
  task automatic run_cmd(input logic dir, input int steps, input int hp, input int abort_at);
    int n;
    int c0;
    int hpe;
    int lim;
    logic [1:0] m;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", int'(cmd_ready), 1);
    c0  = cyc;
    hpe = (hp == 0) ? 1 : hp;
    cmd_valid       = 1'b1;
    cmd_dir         = dir;
    cmd_steps       = 8'(steps);
    cmd_half_period = 16'(hp);
    m = model_ab;
    for (int k = 1; k <= steps; k++) begin
      if (abort_at < 0 || k * hpe <= abort_at) begin
        m = model_next(m, dir);
        exp_q.push_back('{kind: 0, val: m, at: c0 + k * hpe});
      end
    end
    if (abort_at < 0) exp_q.push_back('{kind: 1, val: m, at: c0 + steps * hpe + 1});
    model_ab = m;
    @(negedge clk);
    cmd_valid       = 1'b0;
    cmd_dir         = ~dir;
    cmd_steps       = 8'($urandom_range(1, 200));
    cmd_half_period = 16'($urandom_range(1, 3));
    if (steps != 0) check("busy_after_accept", int'(busy), 1);
    if (abort_at >= 0) begin
      while (cyc < c0 + abort_at) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_ready", int'(cmd_ready), 1);
      check("abort_no_done", int'(done), 0);
      repeat (hpe + 2) @(negedge clk);
      check("abort_hold_busy", int'(busy), 0);
    end else begin
      lim = c0 + steps * hpe + 20;
      while (!done && cyc < lim) @(negedge clk);
      check("done_seen", int'(done), 1);
      check("ready_with_done", int'(cmd_ready), 1);
      check("busy_with_done", int'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
    end
  endtask

  typedef struct {
    logic       dir;
    int         steps;
    int         hp;
    logic [1:0] final_ab;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{dir: 1'b1, steps: 4, hp: 3, final_ab: 2'b00};
    vecs[1] = '{dir: 1'b0, steps: 2, hp: 0, final_ab: 2'b11};
    vecs[2] = '{dir: 1'b1, steps: 0, hp: 5, final_ab: 2'b11};
    vecs[3] = '{dir: 1'b1, steps: 3, hp: 1, final_ab: 2'b10};
    vecs[4] = '{dir: 1'b0, steps: 5, hp: 2, final_ab: 2'b00};
    vecs[5] = '{dir: 1'b1, steps: 1, hp: 7, final_ab: 2'b10};
    vecs[6] = '{dir: 1'b0, steps: 1, hp: 2, final_ab: 2'b00};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = '0;
    cmd_half_period = '0;
    abort = 1'b0;
    #1;
    check("rst_ab", int'({rotary_a, rotary_b}), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].dir, vecs[i].steps, vecs[i].hp, -1);
      check($sformatf("final_ab_%0d", i), int'({rotary_a, rotary_b}), int'(vecs[i].final_ab));
    end

    // Abort lands on the cycle that would commit the third edge.
    run_cmd(1'b1, 8, 4, 11);
    check("abort_hold_ab", int'({rotary_a, rotary_b}), 3);
    run_cmd(1'b1, 2, 1, -1);
    check("resume_ab", int'({rotary_a, rotary_b}), 0);

    // Abort together with a valid command in idle: not accepted.
    cmd_valid = 1'b1;
    cmd_steps = 8'd3;
    cmd_half_period = 16'd1;
    abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    check("idle_abort_ab", int'({rotary_a, rotary_b}), 0);

    // Asynchronous reset mid-command, checked before any further clock edge.
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    cmd_steps = 8'd4;
    cmd_half_period = 16'd2;
    exp_q.push_back('{kind: 0, val: 2'b10, at: cyc + 2});
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_ab", int'({rotary_a, rotary_b}), 2);
    check("pre_reset_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    mon_en = 1'b0;
    check("mid_rst_ab", int'({rotary_a, rotary_b}), 0);
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    model_ab = 2'b00;
    prev_ab = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 2, 2, -1);
    check("post_reset_ab", int'({rotary_a, rotary_b}), 3);
    repeat (3) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
